// File: rtl/fpr_cdb_arbiter_pkg.sv
// fpr_cdb_arbiter_pkg: shared FPR CDB types, requester indices and widths
package fpr_cdb_arbiter_pkg;
  localparam int ROB_WIDTH = 6;
  localparam int N_FPR_CDB_REQ = 4;
  typedef enum logic [1:0] {
    REQ_FMOV = 2'd0,
    REQ_FADD = 2'd1,
    REQ_FMUL = 2'd2,
    REQ_FDIV = 2'd3
  } fpr_cdb_req_e;
  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;
endpackage

// File: rtl/fpr_cdb_arbiter_if.sv
// fpr_cdb_arbiter_if: per-unit request/grant handshake plus tag and result register
interface fpr_cdb_arbiter_if
  import fpr_cdb_arbiter_pkg::*;
#(
  parameter int N = N_FPR_CDB_REQ
);
  logic [N-1:0]         valid;
  logic [N-1:0]         ready;
  logic [ROB_WIDTH-1:0] tag  [N];
  logic [31:0]          data [N];
  modport master (output valid, tag, data, input ready);
  modport slave  (input valid, tag, data, output ready);
endinterface

// File: rtl/fpr_cdb_arbiter_rr_pick.sv
// fpr_cdb_arbiter_rr_pick: combinational round-robin priority encoder starting at ptr
module fpr_cdb_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  // scan from ptr upward with wrap, first set request wins
  always_comb begin
    any = 1'b0;
    idx = '0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = W'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
  end
  assign onehot = any ? N'(1) << idx : '0;
endmodule

// File: rtl/fpr_cdb_arbiter.sv
// fpr_cdb_arbiter: round-robin arbitration of FP units onto the single FPR common data bus
module fpr_cdb_arbiter
  import fpr_cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = N_FPR_CDB_REQ,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  fpr_cdb_arbiter_if.slave   req,
  output cdb_t               fpr_cdb,
  output logic [CNT_W-1:0]   busy_cnt,
  output logic [CNT_W-1:0]   conflict_cnt
);
  localparam int W = $clog2(N_REQ);
  logic                 any;
  logic [N_REQ-1:0]     onehot;
  logic [W-1:0]         idx;
  logic [W-1:0]         rr_ptr;
  logic [W-1:0]         g_idx;
  logic                 g_valid;
  logic [ROB_WIDTH-1:0] g_tag;
  logic                 multi;
  fpr_cdb_arbiter_rr_pick #(.N(N_REQ), .W(W)) u_pick (
    .req    (req.valid),
    .ptr    (rr_ptr),
    .any    (any),
    .onehot (onehot),
    .idx    (idx)
  );
  // grant is suppressed while reset so nothing dispatches in a flush cycle
  always_comb begin
    req.ready = reset ? '0 : onehot;
    multi = $countones(req.valid) > 1;
  end
  // broadcast the previous grant; a flush kills the pending broadcast
  always_comb begin
    fpr_cdb.valid = g_valid && !reset;
    fpr_cdb.tag = g_tag;
    fpr_cdb.data = req.data[g_idx];
  end
  // grant registers and round-robin pointer; pointer moves past the winner
  always_ff @(posedge clk) begin
    if (reset) begin
      g_valid <= 1'b0;
      g_idx <= '0;
      g_tag <= '0;
      rr_ptr <= '0;
    end else begin
      g_valid <= any;
      if (any) begin
        g_idx <= idx;
        g_tag <= req.tag[idx];
        rr_ptr <= (idx == W'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end
  // saturating bus-busy and contention counters
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      busy_cnt <= busy_cnt + CNT_W'(fpr_cdb.valid && !(&busy_cnt));
      conflict_cnt <= conflict_cnt + CNT_W'(multi && !(&conflict_cnt));
    end
  end
endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// tb_fpr_cdb_arbiter: scoreboard bench for grant order, broadcast timing, flush and counters
module tb_fpr_cdb_arbiter;
  import fpr_cdb_arbiter_pkg::*;
  localparam int N = 4;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  fpr_cdb_arbiter_if #(.N(N)) bus ();
  cdb_t fpr_cdb;
  logic [CNT_W-1:0] busy_cnt;
  logic [CNT_W-1:0] conflict_cnt;
  fpr_cdb_arbiter #(.N_REQ(N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (bus),
    .fpr_cdb      (fpr_cdb),
    .busy_cnt     (busy_cnt),
    .conflict_cnt (conflict_cnt)
  );
  typedef struct {
    int                   due;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic [31:0] nxt_data [N];
  // unit model: result register loads on its grant edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) if (bus.ready[i]) bus.data[i] <= nxt_data[i];
  end
  // bus monitor: every cycle either the due broadcast or an idle bus
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      total++;
      if (fpr_cdb !== {1'b1, e.tag, e.data}) begin
        bad++;
        $display("FAIL cdb cyc=%0d got v=%b tag=%0d data=%h want v=1 tag=%0d data=%h",
                 cyc, fpr_cdb.valid, fpr_cdb.tag, fpr_cdb.data, e.tag, e.data);
      end
    end else begin
      total++;
      if (fpr_cdb.valid !== 1'b0) begin
        bad++;
        $display("FAIL cdb_idle cyc=%0d got valid=%b want 0", cyc, fpr_cdb.valid);
      end
    end
  end
  task automatic cycle(input logic rst, input logic [N-1:0] v, input int exp, input string nm);
    logic [N-1:0] want;
    @(posedge clk);
    #1;
    reset = rst;
    bus.valid = v;
    for (int i = 0; i < N; i++) begin
      bus.tag[i] = ROB_WIDTH'($urandom_range(0, 63));
      nxt_data[i] = $urandom;
    end
    if (rst) q.delete();
    #1;
    want = (exp >= 0) ? N'(1) << exp : '0;
    total++;
    if (bus.ready !== want) begin
      bad++;
      $display("FAIL %s ready got=%b want=%b", nm, bus.ready, want);
    end
    if (exp >= 0) q.push_back('{cyc + 1, bus.tag[exp], nxt_data[exp]});
  endtask
  task automatic test_reset();
    cycle(1'b1, '1, -1, "reset_a");
    cycle(1'b1, '1, -1, "reset_b");
    cycle(1'b0, '0, -1, "post_reset");
    total++;
    if (busy_cnt !== '0 || conflict_cnt !== '0) begin
      bad++;
      $display("FAIL reset_cnt got busy=%0d conflict=%0d want 0 0", busy_cnt, conflict_cnt);
    end
  endtask
  task automatic test_single();
    @(posedge clk);
    #1;
    bus.valid = 4'b0010;
    bus.tag[1] = ROB_WIDTH'(5);
    nxt_data[1] = 32'h3f800000;
    #1;
    total++;
    if (bus.ready !== 4'b0010) begin
      bad++;
      $display("FAIL single ready got=%b want=0010", bus.ready);
    end
    q.push_back('{cyc + 1, ROB_WIDTH'(5), 32'h3f800000});
    cycle(1'b0, '0, -1, "single_idle");
  endtask
  task automatic test_round_robin();
    cycle(1'b1, '1, -1, "rr_reset");
    for (int k = 0; k < 8; k++) cycle(1'b0, '1, k % 4, "rr_order");
    cycle(1'b0, '0, -1, "rr_drain");
    cycle(1'b0, '0, -1, "rr_idle");
    total++;
    if (busy_cnt !== 4'd8 || conflict_cnt !== 4'd8) begin
      bad++;
      $display("FAIL rr_cnt got busy=%0d conflict=%0d want 8 8", busy_cnt, conflict_cnt);
    end
  endtask
  task automatic test_wrap_skip();
    cycle(1'b0, '1, 0, "wrap_pre0");
    cycle(1'b0, '1, 1, "wrap_pre1");
    cycle(1'b0, '1, 2, "wrap_pre2");
    cycle(1'b0, 4'b0011, 0, "wrap_to0");
    cycle(1'b0, 4'b0011, 1, "wrap_then1");
  endtask
  task automatic test_idle_gap();
    cycle(1'b0, 4'b1000, 3, "gap_grant3");
    cycle(1'b0, '0, -1, "gap_idle0");
    cycle(1'b0, '0, -1, "gap_idle1");
    cycle(1'b0, 4'b1010, 1, "gap_ptr_hold");
  endtask
  task automatic test_midop_reset();
    cycle(1'b0, 4'b0100, 2, "flush_grant2");
    cycle(1'b1, '1, -1, "flush_reset");
    cycle(1'b0, 4'b1001, 0, "flush_ptr0");
    cycle(1'b0, '0, -1, "flush_drain");
  endtask
  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'b0100, 2, "b2b_same");
    cycle(1'b0, '0, -1, "b2b_drain");
  endtask
  task automatic test_saturate();
    cycle(1'b1, '1, -1, "sat_reset");
    for (int k = 0; k < 20; k++) cycle(1'b0, '1, k % 4, "sat_order");
    cycle(1'b0, '0, -1, "sat_drain");
    cycle(1'b0, '0, -1, "sat_idle");
    total++;
    if (busy_cnt !== 4'hf || conflict_cnt !== 4'hf) begin
      bad++;
      $display("FAIL sat_cnt got busy=%0d conflict=%0d want 15 15", busy_cnt, conflict_cnt);
    end
  endtask
  initial begin
    bus.valid = '0;
    for (int i = 0; i < N; i++) begin
      bus.tag[i] = '0;
      nxt_data[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_idle_gap();
    test_midop_reset();
    test_back_to_back();
    test_saturate();
    @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
